serial_adder: RTL and testbench
===============================

# serial_adder

Multi-cycle, parametrised N-bit adder/subtractor that computes its result W bits per clock through one shared W-bit chunk adder. It trades latency for area compared with a full-width combinational ripple adder. It adds a subtract mode, carry-out and signed-overflow flags, and valid/ready handshakes on input and output. It sits in the datapath wherever a narrow, registered add/sub unit with back-pressure is needed.

## Interface
- N, default 16: operand width in bits; must be an integer multiple of W (elaboration error otherwise).
- W, default 4: chunk width processed per cycle; 1 ≤ W ≤ N.
- C (localparam) = N/W: number of chunk cycles.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation.
- A  input  N  operand A, unsigned or two's complement.
- B  input  N  operand B.
- Sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- Sum  output  N  result, low N bits.
- Cout  output  1  carry out of bit N−1 (for Sub: 1 = no borrow).
- Ovf  output  1  signed overflow: carry into bit N−1 XOR carry out of bit N−1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, latch B^{N{Sub}}, carry ← Sub, chunk index k ← 0, state → RUN.
- RUN, each cycle:
  - Chunk k = bits [kW+W−1 : kW] of A and B' go through the chunk adder with the carry register.
  - The W-bit result is written into Sum[kW+W−1:kW].
  - The carry register takes the chunk carry-out; k increments.
  - On k=C−1, also capture Cout and Ovf (from carry into MSB and carry out of MSB), then state → DONE.
- DONE:
  - out_valid=1; Sum, Cout and Ovf are stable.
  - On out_ready → IDLE.
- in_ready=0 in RUN and DONE; inputs are ignored there.
- Arithmetic:
  - Sum = (A + (Sub ? ~B : B) + Sub) mod 2^N.
  - Cout is bit N of the same sum.
- W=N degenerates to a single RUN cycle; same protocol.
- Result registers are not cleared between operations. Only Sum bits of the current op are valid once out_valid is set.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, k=0, carry=0, Sum=0, Cout=0, Ovf=0, out_valid=0.
  - in_ready is forced 0 while rst_n=0 and goes to 1 the cycle after release.
- Reset mid-RUN or mid-DONE aborts the operation; no out_valid follows.
- Latency: accept at edge e0; chunks at edges e1..eC; out_valid high from eC until the handshake edge.
- Throughput: one op per C+2 cycles. IDLE is re-entered on the out handshake edge, and the next accept happens at the following edge at the earliest.
- No same-cycle result-handshake + new-accept (in_ready=0 in DONE).
- out_ready held low: stay in DONE indefinitely with outputs stable.
- in_valid may drop without acceptance; there is no requirement to hold it.

## Structure
- Shared package adder_pkg holds the state typedef (IDLE/RUN/DONE) and the N % W legality check helper.
- One sub-module, chunk_adder: W-bit combinational ripple built from full_adder instances.
  - Inputs: A, B, Cin.
  - Outputs: Sum[W−1:0], Cout, Cmsb (carry into bit W−1).
- serial_adder holds the FSM, chunk counter (width $clog2(C)+1), operand and result registers, and the operand mux.

## Test plan
All cases with N=16, W=4 unless stated.
- Add: A=0x1234, B=0x4321, Sub=0 → after 4 RUN cycles out_valid=1, Sum=0x5555, Cout=0, Ovf=0.
- Carry/overflow: A=0xFFFF, B=0x0001 → Sum=0x0000, Cout=1, Ovf=0. A=0x7FFF, B=0x0001 → Sum=0x8000, Cout=0, Ovf=1.
- Subtract: A=0x0005, B=0x0007, Sub=1 → Sum=0xFFFE, Cout=0, Ovf=0. A=0x8000, B=0x0001, Sub=1 → Sum=0x7FFF, Cout=1, Ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready=0; in_valid pulses are ignored.
  - Release out_ready → IDLE; the next op is accepted one cycle later.
- Reset mid-RUN: drop rst_n at k=2 → next cycle all outputs at reset values, no out_valid. A fresh op (0x0001+0x0001) gives Sum=0x0002.
- Parameter sweep: (N,W) ∈ {(8,1),(16,16),(32,8)} with 1000 random A/B/Sub vs. reference model. Latency is exactly C cycles accept→out_valid.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the serial add/sub datapath.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk width must be non-zero, no wider than the operand, and divide it evenly.
  function automatic bit n_w_legal(input int unsigned n, input int unsigned w);
    return (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// W-bit combinational ripple adder; also exposes the carry into its MSB for overflow.
module chunk_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Cmsb
);

  logic [W:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i   (A[i]),
      .b_i   (B[i]),
      .ci_i  (carry[i]),
      .sum_c (Sum[i]),
      .cout_c(carry[i+1])
    );
  end

  assign Cout = carry[W];
  assign Cmsb = carry[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the chunk ripple chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a_i ^ b_i ^ ci_i;
  assign cout_c = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// N-bit add/sub computed W bits per cycle through one shared chunk adder,
// with valid/ready handshakes on both sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int unsigned C  = N / W;
  localparam int unsigned KW = $clog2(C) + 1;

  if (!n_w_legal(N, W)) begin : g_bad_params
    $error("serial_adder: N must be a non-zero multiple of W with W <= N");
  end

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   ch_a, ch_b, ch_sum;
  logic           ch_cout, ch_cmsb;
  logic           last_chunk;

  // Operand mux: select chunk k of the latched operands.
  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int unsigned i = 0; i < C; i++) begin
      if (k_q == KW'(i)) begin
        ch_a = a_q[i*W +: W];
        ch_b = b_q[i*W +: W];
      end
    end
  end

  chunk_adder #(.W(W)) u_chunk (
    .A   (ch_a),
    .B   (ch_b),
    .Cin (carry_q),
    .Sum (ch_sum),
    .Cout(ch_cout),
    .Cmsb(ch_cmsb)
  );

  assign last_chunk = (k_q == KW'(C - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtract folds into add: invert B and inject a carry of one.
          a_d     = A;
          b_d     = B ^ {N{Sub}};
          carry_d = Sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < C; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[i*W +: W] = ch_sum;
          end
        end
        carry_d = ch_cout;
        k_d     = k_q + KW'(1);
        if (last_chunk) begin
          cout_d  = ch_cout;
          ovf_d   = ch_cout ^ ch_cmsb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, back-pressure and
// reset corner sequences at N=16/W=4, plus a random sweep over three other shapes.
module tb_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    string       nm;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [33:0] e8;
    logic [33:0] e16;
    logic [33:0] e32;
  } swexp_t;

  int n_err = 0;
  int n_chk = 0;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance: N=16, W=4.
  logic        in_valid, in_ready, out_valid, out_ready, Sub, Cout, Ovf;
  logic [15:0] A, B, Sum;

  // Sweep instances share stimulus; each drives its own outputs.
  logic [31:0] sw_a, sw_b;
  logic        sw_sub, sw_iv, sw_or;
  logic        s8_ir,  s8_ov,  s8_co,  s8_of;
  logic        s16_ir, s16_ov, s16_co, s16_of;
  logic        s32_ir, s32_ov, s32_co, s32_of;
  logic [7:0]  s8_sum;
  logic [15:0] s16_sum;
  logic [31:0] s32_sum;

  res_t   sb[$];
  swexp_t sq[$];

  always #5 clk = ~clk;

  serial_adder #(.N(16), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  serial_adder #(.N(8), .W(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv), .in_ready(s8_ir),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Sub(sw_sub), .out_valid(s8_ov), .out_ready(sw_or),
    .Sum(s8_sum), .Cout(s8_co), .Ovf(s8_of)
  );

  serial_adder #(.N(16), .W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv), .in_ready(s16_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .Sub(sw_sub), .out_valid(s16_ov), .out_ready(sw_or),
    .Sum(s16_sum), .Cout(s16_co), .Ovf(s16_of)
  );

  serial_adder #(.N(32), .W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv), .in_ready(s32_ir),
    .A(sw_a), .B(sw_b), .Sub(sw_sub), .out_valid(s32_ov), .out_ready(sw_or),
    .Sum(s32_sum), .Cout(s32_co), .Ovf(s32_of)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from full-width arithmetic and the sign rule.
  function automatic logic [33:0] ref_add(input int unsigned n, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] m, aa, bb, full, r, msb;
    logic        sa, sbit, sr, co, ov;
    m    = (64'd1 << n) - 64'd1;
    msb  = 64'd1 << (n - 1);
    aa   = {32'd0, a} & m;
    bb   = {32'd0, (s ? ~b : b)} & m;
    full = aa + bb + 64'(s);
    r    = full & m;
    co   = |(full & (64'd1 << n));
    sa   = |(aa & msb);
    sbit = |(bb & msb);
    sr   = |(r & msb);
    ov   = (sa == sbit) && (sr != sa);
    return {ov, co, r[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int hold, input string nm);
    int   cyc;
    res_t r;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    A = a; B = b; Sub = s; in_valid = 1'b1;
    tick();
    sb.push_back('{es, ec, eo});
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd4);
    r = sb.pop_front();
    chk({nm, " sum"},  64'(Sum),  64'(r.sum));
    chk({nm, " cout"}, 64'(Cout), 64'(r.cout));
    chk({nm, " ovf"},  64'(Ovf),  64'(r.ovf));
    chk({nm, " busy"}, 64'(in_ready), 64'd0);
    for (int j = 0; j < hold; j++) begin
      in_valid = 1'($urandom); A = 16'($urandom); B = 16'($urandom);
      tick();
      chk({nm, " hold"}, 64'({out_valid, in_ready, Cout, Ovf, Sum}),
          64'({1'b1, 1'b0, r.cout, r.ovf, r.sum}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " released"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  vec_t tbl[9];

  initial begin
    int     cyc, l8, l16, l32, seen;
    swexp_t e;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic"};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry"};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero"};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_negovf"};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_self"};
    tbl[8] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, "add_ripple"};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Sub = 1'b0;
    sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_iv = 1'b0; sw_or = 1'b0;
    repeat (3) tick();
    chk("reset outputs", 64'({out_valid, in_ready, Cout, Ovf, Sum}), 64'd0);
    rst_n = 1'b1;
    chk("ready at release", 64'(in_ready), 64'd0);
    tick();
    chk("ready after release", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0, tbl[i].nm);
    end

    // Back-pressure, then an immediate follow-on op.
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 10, "backpressure");
    do_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 0, "after_bp");

    // Reset while the third chunk is pending.
    A = 16'h00F0; B = 16'h0F0F; Sub = 1'b0; in_valid = 1'b1;
    tick();
    sb.push_back('{16'h0FFF, 1'b0, 1'b0});
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    void'(sb.pop_back());
    tick();
    chk("midrun reset outputs", 64'({out_valid, in_ready, Cout, Ovf, Sum}), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (out_valid) seen++;
      if (j == 0) chk("midrun ready back", 64'(in_ready), 64'd1);
    end
    chk("midrun no out_valid", 64'(seen), 64'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, "rst_fresh");
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    // Random sweep across (8,1), (16,16), (32,8) in lockstep.
    for (int i = 0; i < 1000; i++) begin
      sw_a = $urandom; sw_b = $urandom; sw_sub = 1'($urandom);
      if (i % 10 == 0) sw_b = ~sw_a;
      if (i % 10 == 1) sw_a = 32'hFFFF_FFFF;
      if (i % 10 == 2) begin sw_a = 32'h8080_8080; sw_b = 32'h8080_8080; end
      cyc = 0;
      while (!(s8_ir && s16_ir && s32_ir) && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("sweep ready", 64'({s8_ir, s16_ir, s32_ir}), 64'd7);
      sw_iv = 1'b1;
      tick();
      sq.push_back('{ref_add(8, sw_a, sw_b, sw_sub), ref_add(16, sw_a, sw_b, sw_sub),
                     ref_add(32, sw_a, sw_b, sw_sub)});
      sw_iv = 1'b0;
      l8 = -1; l16 = -1; l32 = -1; cyc = 0;
      while (!(s8_ov && s16_ov && s32_ov) && cyc < 40) begin
        tick();
        cyc++;
        if (s8_ov  && l8  < 0) l8  = cyc;
        if (s16_ov && l16 < 0) l16 = cyc;
        if (s32_ov && l32 < 0) l32 = cyc;
      end
      e = sq.pop_front();
      chk("sweep8 latency",  64'(l8),  64'd8);
      chk("sweep16 latency", 64'(l16), 64'd1);
      chk("sweep32 latency", 64'(l32), 64'd4);
      chk("sweep8 result",  64'({s8_of,  s8_co,  32'(s8_sum)}),  64'(e.e8));
      chk("sweep16 result", 64'({s16_of, s16_co, 32'(s16_sum)}), 64'(e.e16));
      chk("sweep32 result", 64'({s32_of, s32_co, s32_sum}),      64'(e.e32));
      sw_or = 1'b1;
      tick();
      sw_or = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
